// File: rtl/fdiv_ratio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fdiv_ratio_ctrl
//  Purpose  : Run-time ratio controller for a 50%-duty integer clock divider.
//             Ratio changes arrive over a REQ/ACK handshake. A new ratio is
//             applied only at a period boundary, so no runt pulse appears.
//             The block drives the posedge phase (div_out) and the odd-ratio
//             stretch flag for the downstream negedge stage.
//  Revision : 1.0 - initial release
// ============================================================================
module fdiv_ratio_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         req,
   input  logic [W-1:0] div_n,
   output logic         ack,
   output logic         err,
   output logic         busy,
   output logic         div_out,
   output logic         stretch,
   output logic         tick,
   output logic [W-1:0] cur_n
);

   // START is the single cycle between accepting a ratio from IDLE and
   // entering period index 0; it behaves like RUN for everything else.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_PEND  = 2'd3
   } state_t;

   state_t       state;
   logic [W-1:0] cnt;
   logic [W-1:0] next_n;

   logic [W-1:0] half;
   logic [W-1:0] cnt_inc;
   logic         at_boundary;
   logic         take;

   assign half        = cur_n >> 1;
   assign cnt_inc     = cnt + W'(1);
   assign at_boundary = (cnt == cur_n - W'(1));
   // A request is not resampled in its own ACK cycle, so a requester that
   // drops REQ on seeing ACK is never served twice. PEND ignores REQ.
   assign take        = req && !ack && (state != S_PEND);

   // Controller FSM, period counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         next_n  <= '0;
         cur_n   <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         div_out <= 1'b0;
         stretch <= 1'b0;
         tick    <= 1'b0;
      end else begin
         ack  <= 1'b0;
         err  <= 1'b0;
         tick <= 1'b0;

         // Divider progress; the first period after a start ignores en.
         case (state)
            S_START: begin
               state   <= S_RUN;
               cnt     <= '0;
               div_out <= 1'b1;
               tick    <= 1'b1;
            end
            S_RUN, S_PEND: begin
               if (en) begin
                  if (at_boundary) begin
                     cnt <= '0;
                     if (state == S_PEND) begin
                        busy <= 1'b0;
                        if (next_n == '0) begin
                           state   <= S_IDLE;
                           cur_n   <= '0;
                           stretch <= 1'b0;
                           div_out <= 1'b0;
                        end else begin
                           state   <= S_RUN;
                           cur_n   <= next_n;
                           stretch <= next_n[0];
                           div_out <= 1'b1;
                           tick    <= 1'b1;
                        end
                     end else begin
                        div_out <= 1'b1;
                        tick    <= 1'b1;
                     end
                  end else begin
                     cnt     <= cnt_inc;
                     div_out <= (cnt_inc < half);
                  end
               end
            end
            default: ;
         endcase

         // Handshake; an acceptance on a boundary edge only takes effect at
         // the following boundary because the state seen here is pre-edge.
         if (take) begin
            ack <= 1'b1;
            if (div_n == W'(1)) begin
               err <= 1'b1;
            end else if (state == S_IDLE) begin
               if (div_n != '0) begin
                  state   <= S_START;
                  cur_n   <= div_n;
                  stretch <= div_n[0];
               end
            end else begin
               state  <= S_PEND;
               next_n <= div_n;
               busy   <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fdiv_ratio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fdiv_ratio_ctrl
//  Purpose  : Self-checking bench for fdiv_ratio_ctrl: vector table, directed
//             corner sequences and randomized traffic against a period model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fdiv_ratio_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       req = 1'b0;
   logic [7:0] div_n = 8'd0;
   logic       ack, err, busy, div_out, stretch, tick;
   logic [7:0] cur_n;

   int checks = 0;
   int errors = 0;

   fdiv_ratio_ctrl #(.W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .req     (req),
      .div_n   (div_n),
      .ack     (ack),
      .err     (err),
      .busy    (busy),
      .div_out (div_out),
      .stretch (stretch),
      .tick    (tick),
      .cur_n   (cur_n)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (period position arithmetic) ---------
   int   m_cur = 0, m_next = 0, m_pos = 0;
   bit   m_run = 0, m_start = 0, m_pend = 0;
   logic e_ack = 0, e_err = 0, e_busy = 0, e_div = 0, e_str = 0, e_tick = 0;
   logic [7:0] e_cur = 0;

   task automatic model_edge();
      bit was_run, was_pend, was_start, take;
      if (rst) begin
         m_cur = 0; m_next = 0; m_pos = 0;
         m_run = 0; m_start = 0; m_pend = 0;
         e_ack = 0; e_err = 0; e_busy = 0; e_div = 0; e_str = 0; e_tick = 0;
         e_cur = 0;
         return;
      end
      was_run   = m_run;
      was_pend  = m_pend;
      was_start = m_start;
      take      = req && !was_pend && !e_ack;
      e_ack = 0; e_err = 0; e_tick = 0;
      if (was_start) begin
         m_start = 0; m_pos = 0; e_tick = 1;
      end else if (was_run && en) begin
         if (m_pos == m_cur - 1) begin
            m_pos = 0;
            if (was_pend) begin
               m_pend = 0;
               if (m_next == 0) begin
                  m_run = 0; m_cur = 0;
               end else begin
                  m_cur = m_next; e_tick = 1;
               end
            end else begin
               e_tick = 1;
            end
         end else begin
            m_pos++;
         end
      end
      if (take) begin
         e_ack = 1;
         if (div_n == 8'd1) e_err = 1;
         else if (was_run) begin m_pend = 1; m_next = int'(div_n); end
         else if (div_n != 8'd0) begin
            m_cur = int'(div_n); m_run = 1; m_start = 1;
         end
      end
      e_busy = m_pend;
      e_cur  = m_cur[7:0];
      e_str  = m_run ? m_cur[0] : 1'b0;
      e_div  = (m_run && !m_start) ? (m_pos < m_cur / 2) : 1'b0;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input bit use_model);
      @(posedge clk);
      model_edge();
      #1;
      if (use_model)
         chk("cycle_vs_model",
             {18'd0, ack, err, busy, div_out, stretch, tick, cur_n},
             {18'd0, e_ack, e_err, e_busy, e_div, e_str, e_tick, e_cur});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1);
   endtask

   task automatic do_reset();
      rst = 1; req = 0; div_n = 0; en = 1;
      step(1);
      rst = 0;
   endtask

   task automatic do_req(input logic [7:0] n, input bit keep);
      bit got;
      got = 0;
      req = 1; div_n = n;
      for (int i = 0; i < 6 && !got; i++) begin
         step(1);
         if (ack === 1'b1) got = 1;
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
      if (!keep) begin req = 0; div_n = 0; end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst, en, req;
      logic [7:0] dn;
      logic [5:0] flags;   // ack, err, busy, div_out, stretch, tick
      logic [7:0] cur;
   } vec_t;

   vec_t vt[14];

   initial begin
      bit         got;
      int         cnt;
      logic [7:0] pick;

      vt[0]  = '{1'b1, 1'b1, 1'b0, 8'd0, 6'b000000, 8'd0};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 8'd5, 6'b100010, 8'd5};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000111, 8'd5};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000110, 8'd5};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000010, 8'd5};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000010, 8'd5};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000010, 8'd5};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000111, 8'd5};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000110, 8'd5};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000010, 8'd5};
      vt[10] = '{1'b0, 1'b1, 1'b1, 8'd1, 6'b110010, 8'd5};
      vt[11] = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000010, 8'd5};
      vt[12] = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000111, 8'd5};
      vt[13] = '{1'b0, 1'b1, 1'b0, 8'd0, 6'b000110, 8'd5};

      for (int i = 0; i < 14; i++) begin
         rst = vt[i].rst; en = vt[i].en; req = vt[i].req; div_n = vt[i].dn;
         step(0);
         chk($sformatf("vec%0d", i),
             {18'd0, ack, err, busy, div_out, stretch, tick, cur_n},
             {18'd0, vt[i].flags, vt[i].cur});
      end
      req = 0; div_n = 0;

      // N=4, then change to 3 requested at c=1
      do_reset();
      do_req(8'd4, 0);
      run(2);
      do_req(8'd3, 0);
      chk("n4to3_busy", {31'd0, busy}, 32'd1);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(1);
         if (busy === 1'b0) got = 1;
      end
      chk("n4to3_busy_clear", {31'd0, got}, 32'd1);
      chk("n4to3_cur", {24'd0, cur_n}, 32'd3);
      chk("n4to3_first", {29'd0, div_out, stretch, tick}, 32'b111);
      step(1); chk("n4to3_c1", {31'd0, div_out}, 32'd0);
      step(1); chk("n4to3_c2", {31'd0, div_out}, 32'd0);
      step(1); chk("n4to3_wrap", {30'd0, div_out, tick}, 32'b11);

      // N=6, rejected ratio 1
      do_reset();
      do_req(8'd6, 0);
      run(3);
      do_req(8'd1, 0);
      chk("rej_err", {31'd0, err}, 32'd1);
      chk("rej_cur", {24'd0, cur_n}, 32'd6);
      chk("rej_busy", {31'd0, busy}, 32'd0);
      run(8);

      // N=3, stop request
      do_reset();
      do_req(8'd3, 0);
      run(2);
      do_req(8'd0, 0);
      chk("stop_busy", {31'd0, busy}, 32'd1);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(1);
         if (cur_n === 8'd0) got = 1;
      end
      chk("stop_idle", {31'd0, got}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("stop_quiet", {29'd0, div_out, stretch, tick}, 32'd0);
         step(1);
      end

      // N=7, EN low for 4 cycles at c=2
      do_reset();
      do_req(8'd7, 0);
      run(3);
      en = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("en_hold", {30'd0, div_out, tick}, 32'b10);
      end
      en = 1;
      cnt = 0; got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(1);
         cnt++;
         if (tick === 1'b1) got = 1;
      end
      chk("en_resume_len", cnt, 32'd5);

      // reset while PEND, held request restarts with N=9
      do_reset();
      do_req(8'd5, 0);
      run(2);
      do_req(8'd9, 1);
      chk("pend9_busy", {31'd0, busy}, 32'd1);
      rst = 1;
      step(1);
      rst = 0;
      chk("rst_outputs", {18'd0, ack, err, busy, div_out, stretch, tick, cur_n}, 32'd0);
      do_req(8'd9, 0);
      for (int i = 0; i < 9; i++) begin
         step(1);
         chk($sformatf("n9_c%0d", i), {31'd0, div_out}, (i < 4) ? 32'd1 : 32'd0);
      end

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if (req && e_ack) begin
            req = 0; div_n = 0;
         end else if (!req && $urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 9))
               0:       pick = 8'd0;
               1:       pick = 8'd1;
               9:       pick = 8'($urandom_range(13, 40));
               default: pick = 8'($urandom_range(2, 12));
            endcase
            req = 1; div_n = pick;
         end
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fdiv_ratio_ctrl.md
# fdiv_ratio_ctrl

Run-time controller for the programmable 50%-duty integer frequency divider. Requesters change the divide ratio through a REQ/ACK handshake. The block applies each new ratio only at a period boundary, so a ratio change never produces a runt pulse. It drives the divider's posedge phase output and the STRETCH flag. A downstream negedge stage ORs a half-cycle-delayed copy of the phase output when STRETCH is high, which gives exact 50% duty for odd ratios.

## Interface
- W, 8, width of ratio and counter; legal ratios 2..2^W-1, ratio 0 = stop.
- CLK  in  1  sole clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable; 0 freezes the divider.
- REQ  in  1  ratio change request, level, held until ACK.
- DIV_N  in  W  requested ratio, valid while REQ=1.
- ACK  out  1  one-cycle pulse: request consumed.
- ERR  out  1  one-cycle pulse with ACK: request rejected (DIV_N=1).
- BUSY  out  1  accepted ratio pending, waiting for boundary.
- DIV_OUT  out  1  posedge phase of divided clock.
- STRETCH  out  1  current ratio is odd; enables downstream negedge OR.
- TICK  out  1  one-cycle pulse in the first cycle of each period.
- CUR_N  out  W  ratio currently in effect (0 in IDLE).

## Operation
- States:
  - IDLE: no ratio, divider stopped.
  - RUN: dividing by CUR_N.
  - PEND: dividing by CUR_N, NEXT_N latched, BUSY=1.
- Period: the cycle index c runs 0..N-1 and wraps. With H = N>>1 (floor), DIV_OUT=1 iff c<H. A period is H ones followed by N-H zeros.
- STRETCH = CUR_N[0] while in RUN or PEND, 0 in IDLE. It changes only at a boundary.
- Request sampled at edge k with REQ=1, state not PEND:
  - DIV_N=1: ACK=ERR=1 in cycle k+1; state and ratio unchanged.
  - IDLE, DIV_N≥2: CUR_N←DIV_N and ACK in cycle k+1. Period c=0 (DIV_OUT=1, TICK=1) starts in cycle k+2. → RUN.
  - IDLE, DIV_N=0: ACK in cycle k+1, stays IDLE.
  - RUN, DIV_N≠1: NEXT_N←DIV_N and ACK in cycle k+1. → PEND, BUSY=1 from k+1.
- In PEND, REQ is not sampled; the requester keeps REQ held and it is serviced after return to RUN.
- Boundary edge: the edge at which c=N-1 and EN=1. If the state was PEND before that edge:
  - NEXT_N≥2: CUR_N←NEXT_N, new period starts at c=0. → RUN.
  - NEXT_N=0: → IDLE, DIV_OUT=0, CUR_N=0, STRETCH=0, no TICK.
- An acceptance that lands on a boundary edge does not apply at that edge. It applies at the following boundary.
- EN=0:
  - c, DIV_OUT and STRETCH hold; TICK=0.
  - Handshake still operates.
  - A pending ratio waits until EN returns and a boundary occurs.
  - EN has no effect in IDLE; the start from IDLE ignores EN. If EN=0 at start, c=0 holds.
- Simultaneous REQ and boundary in RUN: accept the request; the boundary proceeds with the old ratio.

## Timing
- Reset values (cycle after RST sampled high): state IDLE, c=0, NEXT_N=0, and all outputs 0 (ACK, ERR, BUSY, DIV_OUT, STRETCH, TICK, CUR_N).
- RST mid-operation discards any pending ratio. An in-flight REQ gets no ACK and must be re-presented after reset.
- All outputs are registered; no combinational path from inputs to outputs.
- Handshake latency: REQ seen at edge k → ACK in cycle k+1.
- Ratio switch latency: at most 2 periods of the old ratio after ACK.
- TICK coincides with the DIV_OUT rising cycle, for N≥2.

## Test plan
- Reset, then REQ DIV_N=5, EN=1 → ACK at k+1. DIV_OUT from k+2: 1,1,0,0,0 repeating. STRETCH=1; TICK every 5 cycles; CUR_N=5.
- DIV_N=4 from IDLE → DIV_OUT 1,1,0,0 repeating, STRETCH=0. REQ DIV_N=3 at c=1 → ACK and BUSY=1. The current 4-cycle period completes, then 1,0,0 repeating, STRETCH=1, BUSY=0.
- Running N=6, REQ DIV_N=1 → ACK+ERR one cycle. CUR_N stays 6, pattern unbroken, BUSY stays 0.
- Running N=3, REQ DIV_N=0 → BUSY=1. After the current period ends, IDLE: DIV_OUT=0, CUR_N=0, TICK stops.
- Running N=7, EN=0 for 4 cycles at c=2 → DIV_OUT holds 1, no TICK. After EN=1 the period resumes at c=3, giving a total of 7 enabled cycles per period.
- PEND with NEXT_N=9, assert RST one cycle → all outputs 0, IDLE. A held REQ with DIV_N=9 then starts cleanly, and the first period is 1,1,1,1,0,0,0,0,0.
